// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for mem_port_arbiter: instruction port, load/store port and
// the memory pins. The arbiter uses the slave modport; the requesters and
// memory side use the master modport.
interface mem_port_arbiter_if #(
  parameter int ADDR = 16,
  parameter int WORD = 32
);
  // Instruction-fetch port
  logic            i_req;
  logic [ADDR-1:0] i_addr;
  logic            i_gnt;
  logic            i_rvalid;
  logic [WORD-1:0] i_rdata;

  // Load/store port
  logic            d_req;
  logic            d_we;
  logic [ADDR-1:0] d_addr;
  logic [WORD-1:0] d_wdata;
  logic            d_gnt;
  logic            d_rvalid;
  logic [WORD-1:0] d_rdata;

  // Memory pins
  logic [ADDR-1:0] mem_a;
  logic            mem_w;
  logic [WORD-1:0] mem_d;
  logic [WORD-1:0] mem_q;

  modport slave (
    input  i_req, i_addr,
    output i_gnt, i_rvalid, i_rdata,
    input  d_req, d_we, d_addr, d_wdata,
    output d_gnt, d_rvalid, d_rdata,
    output mem_a, mem_w, mem_d,
    input  mem_q
  );

  modport master (
    output i_req, i_addr,
    input  i_gnt, i_rvalid, i_rdata,
    output d_req, d_we, d_addr, d_wdata,
    input  d_gnt, d_rvalid, d_rdata,
    input  mem_a, mem_w, mem_d,
    output mem_q
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory with a one-cycle registered
// read between the instruction port (reads only) and the load/store port.
// One access is accepted per cycle; read data is steered back to the issuer
// in the following cycle.
// Build option: define MEMARB_RR_EN for round-robin arbitration; otherwise
// the load/store port has fixed priority over the instruction port.
module mem_port_arbiter #(
  parameter int ADDR = 16,
  parameter int WORD = 32
) (
  input  logic                clk,
  input  logic                rst,
  mem_port_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    RSP_NONE = 2'd0,
    RSP_I    = 2'd1,
    RSP_D    = 2'd2
  } rsp_e;

  rsp_e            rsp_own_r;
  rsp_e            rsp_own_s;
  logic            i_win_s;
  logic            d_win_s;
  logic [ADDR-1:0] mem_a_s;
  logic [ADDR-1:0] mem_a_last_r;
  logic            mem_w_s;
  logic [WORD-1:0] mem_d_s;

`ifdef MEMARB_RR_EN
  // 1 = the load/store port won the most recent accepted access
  logic            last_d_r;
`endif

  // Grant selection; nothing is granted while reset is held
  always_comb begin
    i_win_s = 1'b0;
    d_win_s = 1'b0;
    if (!rst) begin
      i_win_s = 1'b0;
      d_win_s = 1'b0;
    end else if (bus.i_req && bus.d_req) begin
`ifdef MEMARB_RR_EN
      if (last_d_r) begin
        i_win_s = 1'b1;
      end else begin
        d_win_s = 1'b1;
      end
`else
      d_win_s = 1'b1;
`endif
    end else begin
      i_win_s = bus.i_req;
      d_win_s = bus.d_req;
    end
  end

  // Memory pin mux; idle cycles re-read the last address with writes off
  always_comb begin
    mem_a_s = mem_a_last_r;
    mem_w_s = 1'b0;
    mem_d_s = {WORD{1'b0}};
    if (i_win_s) begin
      mem_a_s = bus.i_addr;
      mem_w_s = 1'b0;
      mem_d_s = {WORD{1'b0}};
    end else if (d_win_s) begin
      mem_a_s = bus.d_addr;
      mem_w_s = bus.d_we;
      mem_d_s = bus.d_wdata;
    end else begin
      mem_a_s = mem_a_last_r;
      mem_w_s = 1'b0;
      mem_d_s = {WORD{1'b0}};
    end
  end

  // Owner of the read data that the memory will present next cycle
  always_comb begin
    rsp_own_s = RSP_NONE;
    if (i_win_s) begin
      rsp_own_s = RSP_I;
    end else if (d_win_s && !bus.d_we) begin
      rsp_own_s = RSP_D;
    end else begin
      rsp_own_s = RSP_NONE;
    end
  end

  // Response owner and held memory address
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_own_r    <= RSP_NONE;
      mem_a_last_r <= {ADDR{1'b0}};
    end else begin
      rsp_own_r    <= rsp_own_s;
      mem_a_last_r <= mem_a_s;
    end
  end

`ifdef MEMARB_RR_EN
  // Last-winner pointer, moved only when an access is accepted
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_d_r <= 1'b1;
    end else if (i_win_s || d_win_s) begin
      last_d_r <= d_win_s;
    end else begin
      last_d_r <= last_d_r;
    end
  end
`endif

  assign bus.i_gnt    = i_win_s;
  assign bus.d_gnt    = d_win_s;
  assign bus.mem_a    = mem_a_s;
  assign bus.mem_w    = mem_w_s;
  assign bus.mem_d    = mem_d_s;
  assign bus.i_rvalid = (rsp_own_r == RSP_I);
  assign bus.d_rvalid = (rsp_own_r == RSP_D);
  assign bus.i_rdata  = bus.mem_q;
  assign bus.d_rdata  = bus.mem_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural memory, a reference
// memory map and a response scoreboard.
module tb_mem_port_arbiter;

  logic clk;
  logic rst;

  mem_port_arbiter_if #(.ADDR(16), .WORD(32)) bus ();

  mem_port_arbiter #(.ADDR(16), .WORD(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural single-port memory with registered read output
  logic [31:0] mem [0:65535];
  always @(posedge clk) begin
    if (bus.mem_w) mem[bus.mem_a] <= bus.mem_d;
    else           bus.mem_q <= mem[bus.mem_a];
  end

  typedef struct {
    logic        is_d;
    logic [31:0] data;
  } rsp_t;

  rsp_t        exp_q [$];
  logic [31:0] ref_mem [int unsigned];
  logic [15:0] last_addr;
  int          checks;
  int          errors;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive, check combinational and response outputs,
  // update the reference model, then advance past the next rising edge.
  task automatic do_cycle(input logic ir, input logic [15:0] ia,
                          input logic dr, input logic dw, input logic [15:0] da,
                          input logic [31:0] dd,
                          input logic eig, input logic edg, input logic rst_mid);
    rsp_t e;
    bus.i_req   = ir;
    bus.i_addr  = ia;
    bus.d_req   = dr;
    bus.d_we    = dw;
    bus.d_addr  = da;
    bus.d_wdata = dd;
    #3;
    chk("i_gnt", {31'b0, bus.i_gnt}, {31'b0, eig});
    chk("d_gnt", {31'b0, bus.d_gnt}, {31'b0, edg});
    if (eig) begin
      chk("mem_a_i", {16'b0, bus.mem_a}, {16'b0, ia});
      chk("mem_w_i", {31'b0, bus.mem_w}, 32'd0);
      chk("mem_d_i", bus.mem_d, 32'd0);
    end else if (edg) begin
      chk("mem_a_d", {16'b0, bus.mem_a}, {16'b0, da});
      chk("mem_w_d", {31'b0, bus.mem_w}, {31'b0, dw});
      if (dw) chk("mem_d_d", bus.mem_d, dd);
    end else begin
      chk("mem_a_idle", {16'b0, bus.mem_a}, {16'b0, last_addr});
      chk("mem_w_idle", {31'b0, bus.mem_w}, 32'd0);
    end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("i_rvalid", {31'b0, bus.i_rvalid}, {31'b0, !e.is_d});
      chk("d_rvalid", {31'b0, bus.d_rvalid}, {31'b0, e.is_d});
      if (e.is_d) chk("d_rdata", bus.d_rdata, e.data);
      else        chk("i_rdata", bus.i_rdata, e.data);
    end else begin
      chk("i_rvalid_idle", {31'b0, bus.i_rvalid}, 32'd0);
      chk("d_rvalid_idle", {31'b0, bus.d_rvalid}, 32'd0);
    end
    if (eig) begin
      e.is_d = 1'b0;
      e.data = ref_mem[32'(ia)];
      exp_q.push_back(e);
      last_addr = ia;
    end else if (edg) begin
      if (dw) begin
        ref_mem[32'(da)] = dd;
      end else begin
        e.is_d = 1'b1;
        e.data = ref_mem[32'(da)];
        exp_q.push_back(e);
      end
      last_addr = da;
    end
    if (rst_mid) begin
      rst = 1'b0;
      exp_q.delete();
      last_addr = 16'h0000;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    last_addr = 16'h0000;
    bus.i_req = 1'b0; bus.i_addr = 16'h0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = 16'h0; bus.d_wdata = 32'h0;
    rst = 1'b1;
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // Reset held with both requests high: nothing granted, pins quiet
    for (int k = 0; k < 3; k++)
      do_cycle(1'b1, 16'h0010, 1'b1, 1'b0, 16'h0200, 32'h0, 1'b0, 1'b0, 1'b0);

    // Release: grant in the first cycle; preload words through the D port
    rst = 1'b1;
    do_cycle(1'b0, 16'h0000, 1'b1, 1'b1, 16'h0010, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0);
    do_cycle(1'b0, 16'h0000, 1'b1, 1'b1, 16'h0001, 32'h11111111, 1'b0, 1'b1, 1'b0);

    // I read pulse, then idle to collect the response
    do_cycle(1'b1, 16'h0010, 1'b0, 1'b0, 16'h0000, 32'h0, 1'b1, 1'b0, 1'b0);
    do_cycle(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 32'h0, 1'b0, 1'b0, 1'b0);

    // D write then read of the same address in consecutive cycles
    do_cycle(1'b0, 16'h0000, 1'b1, 1'b1, 16'h0200, 32'h12345678, 1'b0, 1'b1, 1'b0);
    do_cycle(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0200, 32'h0, 1'b0, 1'b1, 1'b0);
    do_cycle(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 32'h0, 1'b0, 1'b0, 1'b0);

    // Pipelined mix: I read, D write, D read back-to-back
    do_cycle(1'b1, 16'h0001, 1'b0, 1'b0, 16'h0000, 32'h0, 1'b1, 1'b0, 1'b0);
    do_cycle(1'b0, 16'h0000, 1'b1, 1'b1, 16'h0002, 32'hA5A5A5A5, 1'b0, 1'b1, 1'b0);
    do_cycle(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0002, 32'h0, 1'b0, 1'b1, 1'b0);
    do_cycle(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 32'h0, 1'b0, 1'b0, 1'b0);

    // I read granted, reset asserted before the accepting edge
    do_cycle(1'b1, 16'h0010, 1'b0, 1'b0, 16'h0000, 32'h0, 1'b1, 1'b0, 1'b1);
    do_cycle(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 32'h0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;

    // Contention: both reads held for four cycles
    for (int k = 0; k < 4; k++) begin
`ifdef MEMARB_RR_EN
      do_cycle(1'b1, 16'h0010, 1'b1, 1'b0, 16'h0200, 32'h0, (k % 2 == 0), (k % 2 == 1), 1'b0);
`else
      do_cycle(1'b1, 16'h0010, 1'b1, 1'b0, 16'h0200, 32'h0, 1'b0, 1'b1, 1'b0);
`endif
    end
    do_cycle(1'b1, 16'h0010, 1'b0, 1'b0, 16'h0000, 32'h0, 1'b1, 1'b0, 1'b0);
    do_cycle(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 32'h0, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter that shares the single-port 32-bit × 64k unified memory between the instruction-fetch port (I) and the load/store port (D) of the processor core. It accepts at most one access per cycle and drives the memory address, write-enable and write-data pins. It tracks the one-cycle read latency of the memory and returns read data to the requester that issued the read. Priority is fixed (D over I) or round-robin, selected at compile time.

## Interface
- ADDR, 16, memory word-address width
- WORD, 32, data word width
- clk  in  1  rising-edge clock for arbiter and memory
- rst  in  1  asynchronous, active-low reset
- i_req  in  1  instruction read request; held with i_addr until granted
- i_addr  in  ADDR  instruction word address
- i_gnt  out  1  request accepted this cycle
- i_rvalid  out  1  i_rdata valid this cycle
- i_rdata  out  WORD  instruction read data
- d_req  in  1  data request; held with d_we/d_addr/d_wdata until granted
- d_we  in  1  1 = write, 0 = read
- d_addr  in  ADDR  data word address
- d_wdata  in  WORD  write data
- d_gnt  out  1  request accepted this cycle
- d_rvalid  out  1  d_rdata valid this cycle (reads only)
- d_rdata  out  WORD  data read data
- mem_a  out  ADDR  memory address
- mem_w  out  1  memory write enable
- mem_d  out  WORD  memory write data
- mem_q  in  WORD  memory registered read output

## Operation
- Grant is combinational from the current requests and the priority state; at most one of i_gnt/d_gnt is high. An access is accepted on the clk edge where req & gnt.
- Winner drives mem_a/mem_w/mem_d the same cycle. With no winner: mem_w = 0 and mem_a holds its last value, so the memory performs a harmless read of the last address. A read started this way never generates rvalid.
- I accesses are always reads: mem_w = 0 and mem_d = 0.
- Response register rsp_own ∈ {NONE, I, D} is loaded on each edge:
  - I if an I read was accepted.
  - D if a D read was accepted (d_we = 0).
  - NONE otherwise, including when a D write was accepted.
- x_rvalid = (rsp_own == x); i_rdata and d_rdata both carry mem_q unmasked. Writes produce no rvalid; d_gnt is their only completion.
- Back-to-back accesses are fully pipelined: one grant per cycle, no bubbles. A grant in the cycle after a read is legal because the memory's output register is not disturbed by writes.
- Requester obligations: keep req and its payload stable until gnt; dropping req without a grant is allowed and cancels the request.
- Reset (rst low, asynchronous): rsp_own = NONE; all gnt = 0, all rvalid = 0, mem_w = 0, mem_a = 0; priority pointer set so that I wins the first conflict. Reset mid-read discards the pending response. Memory contents are not reset.

## Timing
- Request-to-grant: 0 cycles when uncontended.
- Grant-to-read-data: exactly 1 cycle; x_rvalid is high in the cycle after the accepting edge.
- Read-after-write, same address, consecutive cycles: returns the new data.
- Contention: the loser waits at least 1 cycle; the worst case is unbounded in fixed mode and 1 cycle in round-robin mode.
- Outputs leave reset in the first cycle after rst deasserts; a request in that cycle may be granted.

## Configuration
- MEMARB_RR_EN defined:
  - Round-robin arbitration with a 1-bit last-winner register, updated only on an accepting edge.
  - On conflict, the requester that did not win last is granted.
  - After reset, last-winner = D, so I wins the first conflict.
- MEMARB_RR_EN undefined:
  - Fixed priority, D over I; no priority state.
  - "I wins first conflict after reset" does not apply; D always wins a conflict.

## Test plan
- Reset: with rst low and both req high, i_gnt = d_gnt = i_rvalid = d_rvalid = mem_w = 0. After rst rises, a grant is issued in the same cycle.
- I read only: preload word 0x0010 = 0xDEADBEEF, pulse i_req/i_addr = 0x0010 for one cycle. Required: i_gnt that cycle; i_rvalid = 1 with i_rdata = 0xDEADBEEF the next cycle; d_rvalid = 0 throughout.
- D write then D read: write 0x12345678 to 0x0200, then read 0x0200 in the next cycle. Required: two consecutive d_gnt, no d_rvalid after the write, and d_rvalid with 0x12345678 one cycle after the read grant.
- Contention, both req held for 4 cycles:
  - RR build: grants I, D, I, D.
  - Fixed build: grants D, D, D, D, with I granted only once d_req drops.
  - Each read's rvalid goes to the matching port one cycle after its grant.
- Reset mid-operation: I read granted, then rst low before the next edge. Required: i_rvalid never asserts, and rsp_own = NONE after release.
- Pipelined mix: I read 0x0001, D write 0x0002 = 0xA5A5A5A5, D read 0x0002 on three consecutive cycles. Required:
  - Cycle 2: i_rvalid = 1 with the old word 0x0001.
  - Cycle 3: no rvalid.
  - Cycle 4: d_rvalid = 1 with d_rdata = 0xA5A5A5A5.
